// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and data width.
// Used by the transmitter and reusable by the matching receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// clr holds the count at zero so the first bit after a clear is full length.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == LAST);

    // Next count: wrap at bit end, hold at zero while cleared.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 (optionally 8E1/8O1), LSB first, idle-high line.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_transmitter: illegal parameter value");
    end

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]                bitidx_q, bitidx_d;
    logic                      tx_q, tx_d;
    logic                      tick;
`ifdef UART_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign ready = (state_q == UART_IDLE);
    assign busy  = ~ready;
    assign tx    = tx_q;

    // Divider is held clear while idle, so every frame starts on a fresh bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_q == UART_IDLE),
        .tick(tick)
    );

    // Next-state, shift register, bit index and done pulse.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitidx_d = bitidx_q;
        done     = 1'b0;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            UART_IDLE: begin
                if (valid) begin
                    shreg_d  = data;
                    bitidx_d = '0;
                    state_d  = UART_START;
`ifdef UART_PARITY_EN
                    parity_d = (^data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            UART_START: begin
                if (tick) begin
                    state_d  = UART_DATA;
                    bitidx_d = '0;
                end
            end
            UART_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bitidx_q == 3'(UART_DATA_BITS - 1)) begin
                        bitidx_d = '0;
`ifdef UART_PARITY_EN
                        state_d  = UART_PARITY;
`else
                        state_d  = UART_STOP;
`endif
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end
            end
            UART_PARITY: begin
`ifdef UART_PARITY_EN
                if (tick) begin
                    state_d  = UART_STOP;
                    bitidx_d = '0;
                end
`else
                state_d = UART_IDLE;
`endif
            end
            UART_STOP: begin
                // bitidx counts stop bits here; done marks the final cycle of the last one.
                if (tick) begin
                    if (bitidx_q == 3'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = UART_IDLE;
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Line value for the upcoming cycle, derived from next state so tx is a clean flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            UART_START:  tx_d = 1'b0;
            UART_DATA:   tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            UART_PARITY: tx_d = parity_d;
`endif
            default:     tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= UART_IDLE;
            shreg_q  <= '0;
            bitidx_q <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitidx_q <= bitidx_d;
            tx_q     <= tx_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
